// File: rtl/sdr_16_rx.sv
// Read-data return stage for the 16-bit SDR SDRAM path: tags each READ, captures two beats, writes one 32-bit word.
// Optional macro SDR_RX_INPUT_REG_EN adds an input register on dq_pad_i and shifts capture/write one cycle later.
module sdr_16_rx #(
    parameter int CL    = 2,
    parameter int BURST = 2
) (
    input  logic        sdram_clk,
    input  logic        wb_rst_n,
    input  logic [2:0]  cmd,
    input  logic        cs_n,
    input  logic [2:0]  fifo_sel,
    input  logic [15:0] dq_pad_i,
    input  logic [7:0]  rx_fifo_full_i,
    output logic [31:0] rx_fifo_dat_o,
    output logic        rx_fifo_we_o,
    output logic [2:0]  rx_fifo_sel_o,
    output logic        rx_busy_o,
    output logic [7:0]  ovf_o,
    input  logic [7:0]  ovf_clr_i,
    output logic        rd_err_o
);

    localparam logic [2:0] CMD_READ = 3'b101;

`ifdef SDR_RX_INPUT_REG_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    localparam int DEPTH   = CL + 2 + XTRA;
    localparam int CAP_STG = CL + XTRA;
    localparam int WR_STG  = CL + 1 + XTRA;

    if (CL != 2 && CL != 3) begin : g_cl_check
        $error("sdr_16_rx: CL must be 2 or 3");
    end
    if (BURST != 2) begin : g_burst_check
        $error("sdr_16_rx: BURST must be 2");
    end

    typedef struct packed {
        logic       vld;
        logic [2:0] sel;
    } tag_t;

    tag_t        tag_q [DEPTH];
    tag_t        tag_d [DEPTH];
    logic [15:0] hi_q, hi_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        rd_err_q, rd_err_d;

    logic        rd_dec;
    logic        rd_clash;
    logic [15:0] dq_cap;
    tag_t        wr_tag;
    logic        wr_full;
    logic        busy;

`ifdef SDR_RX_INPUT_REG_EN
    logic [15:0] dq_q;

    always_ff @(posedge sdram_clk) begin
        dq_q <= dq_pad_i;
    end

    assign dq_cap = dq_q;
`else
    assign dq_cap = dq_pad_i;
`endif

    assign rd_dec   = !cs_n && (cmd == CMD_READ);
    // A READ one cycle behind another makes the older burst unusable on the bus.
    assign rd_clash = rd_dec && tag_q[0].vld;
    assign wr_tag   = tag_q[WR_STG];
    assign wr_full  = rx_fifo_full_i[wr_tag.sel];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag_d[i] = '0;
        end
        tag_d[0].vld = rd_dec;
        tag_d[0].sel = rd_dec ? fifo_sel : 3'd0;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        tag_d[1].vld = tag_q[0].vld && !rd_clash;

        hi_d = tag_q[CAP_STG].vld ? dq_cap : hi_q;

        we_d  = wr_tag.vld && !wr_full;
        dat_d = dat_q;
        sel_d = sel_q;
        if (we_d) begin
            dat_d = {hi_q, dq_cap};
            sel_d = wr_tag.sel;
        end

        // Clear first so a same-edge overflow set takes priority.
        ovf_d = ovf_q & ~ovf_clr_i;
        if (wr_tag.vld && wr_full) begin
            ovf_d[wr_tag.sel] = 1'b1;
        end

        rd_err_d = rd_err_q || rd_clash;

        busy = rd_dec;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy || tag_q[i].vld;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            hi_q     <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            ovf_q    <= '0;
            rd_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
            hi_q     <= hi_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            ovf_q    <= ovf_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign rx_fifo_dat_o = dat_q;
    assign rx_fifo_we_o  = we_q;
    assign rx_fifo_sel_o = sel_q;
    assign rx_busy_o     = busy;
    assign ovf_o         = ovf_q;
    assign rd_err_o      = rd_err_q;

endmodule

// File: tb/tb_sdr_16_rx.sv
// Scoreboard bench for sdr_16_rx: expected words queued at READ issue, compared when the write strobe fires.
module tb_sdr_16_rx;

    localparam int CL = 2;
`ifdef SDR_RX_INPUT_REG_EN
    localparam int LAT = CL + 3;
`else
    localparam int LAT = CL + 2;
`endif
    localparam int INF = 1 << 30;

    logic        sdram_clk;
    logic        wb_rst_n;
    logic [2:0]  cmd;
    logic        cs_n;
    logic [2:0]  fifo_sel;
    logic [15:0] dq_pad_i;
    logic [7:0]  rx_fifo_full_i;
    logic [31:0] rx_fifo_dat_o;
    logic        rx_fifo_we_o;
    logic [2:0]  rx_fifo_sel_o;
    logic        rx_busy_o;
    logic [7:0]  ovf_o;
    logic [7:0]  ovf_clr_i;
    logic        rd_err_o;

    sdr_16_rx #(.CL(CL), .BURST(2)) dut (
        .sdram_clk      (sdram_clk),
        .wb_rst_n       (wb_rst_n),
        .cmd            (cmd),
        .cs_n           (cs_n),
        .fifo_sel       (fifo_sel),
        .dq_pad_i       (dq_pad_i),
        .rx_fifo_full_i (rx_fifo_full_i),
        .rx_fifo_dat_o  (rx_fifo_dat_o),
        .rx_fifo_we_o   (rx_fifo_we_o),
        .rx_fifo_sel_o  (rx_fifo_sel_o),
        .rx_busy_o      (rx_busy_o),
        .ovf_o          (ovf_o),
        .ovf_clr_i      (ovf_clr_i),
        .rd_err_o       (rd_err_o)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        int          wr_edge;
        logic [2:0]  sel;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb [$];
    bit          read_at [int];
    logic [15:0] dq_map [int];
    int          edge_cnt = 0;
    int          last_push_e0 = -10;
    int          rd_err_edge = INF;
    int          rst_edge = 0;
    bit          mon_en = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge sdram_clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic bit busy_exp(input int n);
        for (int e = n - LAT + 1; e <= n + 1; e++) begin
            if (read_at.exists(e) && !(e <= rst_edge && n >= rst_edge)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit rd_err_exp(input int n);
        return (rd_err_edge != INF) && (rd_err_edge <= n) && (rd_err_edge > rst_edge || rst_edge > n);
    endfunction

    // Drive the inputs seen at the next rising edge, then advance past it.
    task automatic tick(input bit rd, input logic [2:0] sel, input logic [15:0] hi,
                        input logic [15:0] lo, input bit rst_lo);
        int e0;
        e0 = edge_cnt + 1;
        wb_rst_n = !rst_lo;
        if (rst_lo) begin
            rst_edge = e0;
            sb.delete();
        end
        if (rd) begin
            cmd      = 3'b101;
            cs_n     = 1'b0;
            fifo_sel = sel;
            if (read_at.exists(e0 - 1)) begin
                if (rd_err_edge == INF || rd_err_edge <= rst_edge) rd_err_edge = e0;
                if (last_push_e0 == e0 - 1 && sb.size() > 0) void'(sb.pop_back());
            end
            read_at[e0] = 1'b1;
            dq_map[e0 + CL + 1] = hi;
            dq_map[e0 + CL + 2] = lo;
            if (!rx_fifo_full_i[sel]) begin
                sb.push_back('{e0 + LAT, sel, {hi, lo}});
                last_push_e0 = e0;
            end else begin
                last_push_e0 = -10;
            end
        end else begin
            cmd      = 3'($urandom);
            cs_n     = 1'($urandom);
            if (cmd == 3'b101) cs_n = 1'b1;
            fifo_sel = 3'($urandom);
        end
        dq_pad_i = dq_map.exists(e0) ? dq_map[e0] : 16'($urandom);
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] sel);
        tick(1'b1, sel, 16'($urandom), 16'($urandom), 1'b0);
    endtask

    always @(negedge sdram_clk) begin
        exp_t e;
        if (mon_en) begin
            if (rx_fifo_we_o) begin
                if (sb.size() == 0) begin
                    check("we_unexpected", 32'(rx_fifo_we_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("we_edge", 32'(edge_cnt), 32'(e.wr_edge));
                    check("we_sel", 32'(rx_fifo_sel_o), 32'(e.sel));
                    check("we_dat", rx_fifo_dat_o, e.dat);
                    $display("write edge %0d sel %0d dat %h", edge_cnt, rx_fifo_sel_o, rx_fifo_dat_o);
                end
            end else if (sb.size() > 0 && sb[0].wr_edge <= edge_cnt) begin
                check("we_missing", 32'(rx_fifo_we_o), 32'd1);
                void'(sb.pop_front());
            end
            check("busy", 32'(rx_busy_o), 32'(busy_exp(edge_cnt)));
            check("rd_err", 32'(rd_err_o), 32'(rd_err_exp(edge_cnt)));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_we"}, 32'(rx_fifo_we_o), 32'd0);
        check({tag, "_dat"}, rx_fifo_dat_o, 32'd0);
        check({tag, "_sel"}, 32'(rx_fifo_sel_o), 32'd0);
        check({tag, "_busy"}, 32'(rx_busy_o), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
        check({tag, "_rderr"}, 32'(rd_err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_n       = 1'b0;
        cmd            = 3'b111;
        cs_n           = 1'b1;
        fifo_sel       = 3'd0;
        dq_pad_i       = 16'd0;
        rx_fifo_full_i = 8'h00;
        ovf_clr_i      = 8'h00;
        #1;
        tick(1'b0, 3'd0, 16'd0, 16'd0, 1'b1);
        tick(1'b0, 3'd0, 16'd0, 16'd0, 1'b1);
        mon_en = 1'b1;
        check_reset_state("reset");

        // Single READ with known beats
        tick(1'b1, 3'd5, 16'hA5A5, 16'h3C3C, 1'b0);
        idle(LAT + 1);
        check("s1_dat", rx_fifo_dat_o, 32'hA5A53C3C);
        check("s1_sel", 32'(rx_fifo_sel_o), 32'd5);

        // Back-to-back READs, one every two cycles
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            idle(1);
        end
        idle(LAT + 1);

        // Randomly spaced READs (spacing >= 2)
        for (int i = 0; i < 10; i++) begin
            rd(3'($urandom));
            idle(1 + $urandom_range(0, 3));
        end
        idle(LAT + 1);

        // Overflow: port 3 full, port 4 not
        rx_fifo_full_i = 8'h08;
        rd(3'd3);
        idle(1);
        rd(3'd4);
        idle(LAT + 1);
        rx_fifo_full_i = 8'h00;
        check("ovf_set", 32'(ovf_o), 32'h08);
        ovf_clr_i = 8'hF7;
        idle(1);
        ovf_clr_i = 8'h00;
        check("ovf_other_clr", 32'(ovf_o), 32'h08);
        ovf_clr_i = 8'h08;
        idle(1);
        ovf_clr_i = 8'h00;
        check("ovf_clr", 32'(ovf_o), 32'h00);

        // Set and clear on the same edge: set wins
        rx_fifo_full_i = 8'h08;
        rd(3'd3);
        idle(LAT - 1);
        ovf_clr_i = 8'h08;
        idle(1);
        ovf_clr_i      = 8'h00;
        rx_fifo_full_i = 8'h00;
        check("ovf_set_wins", 32'(ovf_o), 32'h08);
        ovf_clr_i = 8'h08;
        idle(1);
        ovf_clr_i = 8'h00;
        check("ovf_clr2", 32'(ovf_o), 32'h00);

        // Illegal spacing: READs on consecutive edges
        rd(3'd6);
        rd(3'd7);
        idle(LAT + 1);
        check("rderr_set", 32'(rd_err_o), 32'd1);
        check("rderr_sel", 32'(rx_fifo_sel_o), 32'd7);
        idle(6);
        check("rderr_sticky", 32'(rd_err_o), 32'd1);

        // Reset landing on the second-beat edge discards the word
        rd(3'd2);
        idle(CL + 1);
        tick(1'b0, 3'd0, 16'd0, 16'd0, 1'b1);
        check_reset_state("midrst");

        // Normal operation after reset
        tick(1'b1, 3'd1, 16'h1234, 16'h5678, 1'b0);
        idle(LAT + 1);
        check("post_rst_dat", rx_fifo_dat_o, 32'h12345678);
        check("post_rst_sel", 32'(rx_fifo_sel_o), 32'd1);
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
